// File: rtl/lane_merge_if.sv
// Bundle of the two lane inputs, the pause control and the merged output/status
// signals of lane_merge. The producer side uses master, the merge block uses slave.
interface lane_merge_if #(
    parameter int DATA_W = 4
);
    logic              valid_0;
    logic [DATA_W-1:0] dataout0;
    logic              valid_1;
    logic [DATA_W-1:0] dataout1;
    logic              pause;

    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              lane_out;
    logic              full_0;
    logic              full_1;
    logic              almost_full_0;
    logic              almost_full_1;
    logic [1:0]        err_overflow;

    modport master (
        output valid_0, dataout0, valid_1, dataout1, pause,
        input  valid_out, data_out, lane_out, full_0, full_1,
               almost_full_0, almost_full_1, err_overflow
    );

    modport slave (
        input  valid_0, dataout0, valid_1, dataout1, pause,
        output valid_out, data_out, lane_out, full_0, full_1,
               almost_full_0, almost_full_1, err_overflow
    );
endinterface

// File: rtl/lane_merge.sv
// Merges two demuxed lanes back into one stream: each lane is buffered in its own
// circular FIFO and a round-robin arbiter pops at most one word per clock.
module lane_merge #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input logic        clk,
    input logic        reset,
    lane_merge_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [1:0]        in_valid;
    logic [DATA_W-1:0] in_data [2];

    logic [DATA_W-1:0] mem    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [CNT_W-1:0]  count  [2];

    logic              last_grant;
    logic              grant;
    logic              pop_any;
    logic [1:0]        non_empty;
    logic [1:0]        pop;
    logic [1:0]        push;
    logic [1:0]        drop;
    logic [DATA_W-1:0] pop_data;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              lane_q;
    logic [1:0]        err_q;

    assign in_valid   = {bus.valid_1, bus.valid_0};
    assign in_data[0] = bus.dataout0;
    assign in_data[1] = bus.dataout1;

    // Arbitration looks only at pre-edge counts, so a word written this edge
    // cannot be popped until the following one.
    always_comb begin
        non_empty = {count[1] != '0, count[0] != '0};
        pop_any   = 1'b0;
        grant     = 1'b0;
        if (!bus.pause && (non_empty != 2'b00)) begin
            pop_any = 1'b1;
            if (non_empty == 2'b11) begin
                grant = ~last_grant;
            end else begin
                grant = non_empty[1];
            end
        end
        pop[0]   = pop_any && !grant;
        pop[1]   = pop_any && grant;
        pop_data = mem[grant][rd_ptr[grant]];
    end

    // A full lane still accepts a word when it is being drained on the same edge.
    always_comb begin
        push = 2'b00;
        drop = 2'b00;
        for (int i = 0; i < 2; i++) begin
            push[i] = in_valid[i] && ((count[i] != FULL_CNT) || pop[i]);
            drop[i] = in_valid[i] && !push[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == LAST_PTR) ? '0 : wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == LAST_PTR) ? '0 : rd_ptr[i] + PTR_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: counts and pointers decide what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // last_grant resets to lane 1 so lane 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            lane_q     <= 1'b0;
            last_grant <= 1'b1;
            err_q      <= 2'b00;
        end else begin
            valid_q <= pop_any;
            if (pop_any) begin
                data_q     <= pop_data;
                lane_q     <= grant;
                last_grant <= grant;
            end
            err_q <= err_q | drop;
        end
    end

    assign bus.valid_out     = valid_q;
    assign bus.data_out      = data_q;
    assign bus.lane_out      = lane_q;
    assign bus.err_overflow  = err_q;
    assign bus.full_0        = (count[0] == FULL_CNT);
    assign bus.full_1        = (count[1] == FULL_CNT);
    assign bus.almost_full_0 = (count[0] >= AFULL_CNT);
    assign bus.almost_full_1 = (count[1] >= AFULL_CNT);
endmodule

// File: tb/tb_lane_merge.sv
// Self-checking bench for lane_merge: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_lane_merge;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lane_merge_if #(.DATA_W(DATA_W)) bus ();

    lane_merge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: one queue per lane plus the expected registered outputs.
    int q0[$];
    int q1[$];
    bit m_last;
    bit m_valid;
    int m_data;
    bit m_lane;
    int m_err;

    typedef struct {
        bit rst_before;
        bit v0; int d0;
        bit v1; int d1;
        bit pause;
        bit e_valid; int e_data; bit e_lane;
        bit e_full1; bit e_afull1; int e_err;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_last  = 1'b1;
        m_valid = 1'b0;
        m_data  = 0;
        m_lane  = 1'b0;
        m_err   = 0;
    endtask

    // Pops from the pre-edge contents first, then appends arrivals if room remains.
    task automatic model_step(input bit v0, input int d0, input bit v1, input int d1, input bit p);
        bit g;
        m_valid = 1'b0;
        if (!p && (q0.size() > 0 || q1.size() > 0)) begin
            if (q0.size() > 0 && q1.size() > 0) g = ~m_last;
            else g = (q1.size() > 0);
            m_valid = 1'b1;
            m_lane  = g;
            m_last  = g;
            m_data  = g ? q1.pop_front() : q0.pop_front();
        end
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else m_err = m_err | 1;
        end
        if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else m_err = m_err | 2;
        end
    endtask

    task automatic applyStimulus(input bit v0, input int d0, input bit v1, input int d1, input bit p);
        @(negedge clk);
        bus.valid_0  = v0;
        bus.dataout0 = DATA_W'(d0);
        bus.valid_1  = v1;
        bus.dataout1 = DATA_W'(d1);
        bus.pause    = p;
        model_step(v0, d0, v1, d1, p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.valid_0  = 1'b0;
        bus.valid_1  = 1'b0;
        bus.pause    = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, " valid_out"}, int'(bus.valid_out), int'(m_valid));
        checkOutput({tag, " data_out"}, int'(bus.data_out), m_data);
        checkOutput({tag, " lane_out"}, int'(bus.lane_out), int'(m_lane));
        checkOutput({tag, " full_0"}, int'(bus.full_0), int'(q0.size() == DEPTH));
        checkOutput({tag, " full_1"}, int'(bus.full_1), int'(q1.size() == DEPTH));
        checkOutput({tag, " almost_full_0"}, int'(bus.almost_full_0), int'(q0.size() >= DEPTH - 1));
        checkOutput({tag, " almost_full_1"}, int'(bus.almost_full_1), int'(q1.size() >= DEPTH - 1));
        checkOutput({tag, " err_overflow"}, int'(bus.err_overflow), m_err);
    endtask

    initial begin
        int got[$];

        //                rst v0 d0   v1 d1   p  ev ed   el f1 af1 err
        vecs[0]  = '{1'b0, 1, 4'hA, 0, 0,   0, 0, 0,    0, 0, 0, 0};
        vecs[1]  = '{1'b0, 0, 0,    0, 0,   0, 1, 4'hA, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 0, 0,    0, 0,   0, 0, 4'hA, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 1, 1,    1, 2,   0, 0, 0,    0, 0, 0, 0};
        vecs[4]  = '{1'b0, 0, 0,    0, 0,   0, 1, 1,    0, 0, 0, 0};
        vecs[5]  = '{1'b0, 0, 0,    0, 0,   0, 1, 2,    1, 0, 0, 0};
        vecs[6]  = '{1'b0, 0, 0,    0, 0,   0, 0, 2,    1, 0, 0, 0};
        vecs[7]  = '{1'b0, 0, 0,    1, 1,   1, 0, 2,    1, 0, 0, 0};
        vecs[8]  = '{1'b0, 0, 0,    1, 2,   1, 0, 2,    1, 0, 0, 0};
        vecs[9]  = '{1'b0, 0, 0,    1, 3,   1, 0, 2,    1, 0, 1, 0};
        vecs[10] = '{1'b0, 0, 0,    1, 4,   1, 0, 2,    1, 1, 1, 0};
        vecs[11] = '{1'b0, 0, 0,    1, 5,   1, 0, 2,    1, 1, 1, 2};
        vecs[12] = '{1'b0, 0, 0,    0, 0,   0, 1, 1,    1, 0, 1, 2};
        vecs[13] = '{1'b0, 0, 0,    0, 0,   0, 1, 2,    1, 0, 0, 2};
        vecs[14] = '{1'b0, 0, 0,    0, 0,   0, 1, 3,    1, 0, 0, 2};
        vecs[15] = '{1'b0, 0, 0,    0, 0,   0, 1, 4,    1, 0, 0, 2};
        vecs[16] = '{1'b0, 0, 0,    0, 0,   0, 0, 4,    1, 0, 0, 2};

        reset        = 1'b1;
        bus.valid_0  = 1'b0;
        bus.dataout0 = '0;
        bus.valid_1  = 1'b0;
        bus.dataout1 = '0;
        bus.pause    = 1'b0;
        model_reset();
        #1;
        checkOutput("reset valid_out", int'(bus.valid_out), 0);
        checkOutput("reset data_out", int'(bus.data_out), 0);
        checkOutput("reset lane_out", int'(bus.lane_out), 0);
        checkOutput("reset err_overflow", int'(bus.err_overflow), 0);
        checkOutput("reset full_0", int'(bus.full_0), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst_before) do_reset();
            applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].pause);
            checkOutput($sformatf("vec%0d valid_out", i), int'(bus.valid_out), int'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d data_out", i), int'(bus.data_out), vecs[i].e_data);
            checkOutput($sformatf("vec%0d lane_out", i), int'(bus.lane_out), int'(vecs[i].e_lane));
            checkOutput($sformatf("vec%0d full_1", i), int'(bus.full_1), int'(vecs[i].e_full1));
            checkOutput($sformatf("vec%0d almost_full_1", i), int'(bus.almost_full_1), int'(vecs[i].e_afull1));
            checkOutput($sformatf("vec%0d err_overflow", i), int'(bus.err_overflow), vecs[i].e_err);
        end

        // Full lane accepting a word because it is drained on the same edge.
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 5 + i, 0, 0, 1);
        checkOutput("fullpop full_0 before", int'(bus.full_0), 1);
        checkOutput("fullpop almost_full_0 before", int'(bus.almost_full_0), 1);
        applyStimulus(1, 9, 0, 0, 0);
        checkOutput("fullpop valid_out", int'(bus.valid_out), 1);
        checkOutput("fullpop data_out", int'(bus.data_out), 5);
        checkOutput("fullpop full_0 after", int'(bus.full_0), 1);
        checkOutput("fullpop err_overflow", int'(bus.err_overflow), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("fullpop drain%0d data_out", i), int'(bus.data_out), 6 + i);
            checkOutput($sformatf("fullpop drain%0d lane_out", i), int'(bus.lane_out), 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fullpop idle valid_out", int'(bus.valid_out), 0);

        // Ten-word stream on lane 0, long enough to wrap both pointers twice.
        do_reset();
        got.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, (i + 3) % 16, 0, 0, 0);
            if (bus.valid_out) got.push_back(int'(bus.data_out));
        end
        for (int c = 0; c < 20 && got.size() < 10; c++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (bus.valid_out) got.push_back(int'(bus.data_out));
        end
        checkOutput("wrap word count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checkOutput($sformatf("wrap word%0d", i), got[i], (i + 3) % 16);
        end

        // Reset between edges with words buffered on lane 1.
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 7 + i, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("midreset pre valid_out", int'(bus.valid_out), 1);
        checkOutput("midreset pre almost_full_1", int'(bus.almost_full_1), 1);
        @(negedge clk);
        #2;
        reset        = 1'b1;
        bus.valid_1  = 1'b1;
        bus.dataout1 = 4'hF;
        #1;
        checkOutput("midreset valid_out", int'(bus.valid_out), 0);
        checkOutput("midreset data_out", int'(bus.data_out), 0);
        checkOutput("midreset full_1", int'(bus.full_1), 0);
        checkOutput("midreset almost_full_1", int'(bus.almost_full_1), 0);
        model_reset();
        repeat (2) @(negedge clk);
        bus.valid_1 = 1'b0;
        reset       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("midreset after%0d valid_out", i), int'(bus.valid_out), 0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 15),
                          $urandom_range(0, 99) < 60, $urandom_range(0, 15),
                          $urandom_range(0, 99) < 40);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/lane_merge.md
LANE_MERGE -- requirements
Module: lane_merge

Interface
REQ-001 SHALL have parameter DATA_W, default 4, width of lane and output data.
REQ-002 SHALL have parameter DEPTH, default 4, entries per lane FIFO (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_0  input  1  lane-0 word present this cycle.
REQ-006 SHALL have port dataout0  input  DATA_W  lane-0 word from demux.
REQ-007 SHALL have port valid_1  input  1  lane-1 word present this cycle.
REQ-008 SHALL have port dataout1  input  DATA_W  lane-1 word from demux.
REQ-009 SHALL have port pause  input  1  high blocks all pops.
REQ-010 SHALL have port valid_out  output  1  data_out/lane_out carry a popped word.
REQ-011 SHALL have port data_out  output  DATA_W  merged output word (registered).
REQ-012 SHALL have port lane_out  output  1  source lane of data_out.
REQ-013 SHALL have ports full_0, full_1  output  1 each  lane FIFO count == DEPTH.
REQ-014 SHALL have ports almost_full_0, almost_full_1  output  1 each  count >= DEPTH-1.
REQ-015 SHALL have port err_overflow  output  2  sticky per-lane dropped-word flag (bit i = lane i).

Function
REQ-016 SHALL contain one circular FIFO per lane with write pointer, read pointer and a count (0..DEPTH).
REQ-017 SHALL push dataoutN at a rising edge when valid_N=1 and (count_N<DEPTH or lane N popped that same edge).
REQ-018 SHALL drop a word arriving when count_N==DEPTH and lane N is not popped that edge, set err_overflow[N], and leave the FIFO contents unchanged.
REQ-019 SHALL keep err_overflow bits set until reset.
REQ-020 SHALL wrap pointers from DEPTH-1 to 0.
REQ-021 SHALL pop at most one word per edge, only when pause=0 and at least one count (pre-edge value) is >0; a word pushed at edge N SHALL be poppable no earlier than edge N+1.
REQ-022 SHALL arbitrate round-robin with a last_grant register: when both lanes are non-empty, grant the lane != last_grant; when one lane is non-empty, grant it; last_grant SHALL update to the granted lane.
REQ-023 SHALL register the popped word onto data_out, the granted lane onto lane_out, and set valid_out=1 at the pop edge.
REQ-024 SHALL drive valid_out=0 after any edge with no pop; data_out and lane_out SHALL then hold their previous values.
REQ-025 SHALL give minimum latency of 2 edges: word sampled at edge N appears on data_out after edge N+1 (lane empty, no contention, pause=0).
REQ-026 SHALL decrement the count on pop and increment it on push; push and pop on the same lane at the same edge SHALL leave the count unchanged.
REQ-027 SHALL derive full_N and almost_full_N combinationally from count_N.
REQ-028 SHALL preserve per-lane ordering; no word SHALL be duplicated or reordered within a lane.

Reset
REQ-029 SHALL, while reset=1 (asynchronously, no clock needed), clear all counts and pointers and set valid_out=0, data_out=0, lane_out=0, err_overflow=2'b00, and last_grant=1 (lane 0 wins the first contention).
REQ-030 SHALL, on reset asserted mid-operation, discard all buffered words; nothing pushed before reset SHALL appear after it.
REQ-031 SHALL ignore valid_0/valid_1 while reset=1; the first push SHALL occur at the first rising edge with reset=0.

Verification
REQ-032 Single lane: valid_0=1, dataout0=4'hA at one edge, pause=0 -> after next edge valid_out=1, data_out=4'hA, lane_out=0, then valid_out=0.
REQ-033 Contention: at one edge valid_0=1 with 4'h1 and valid_1=1 with 4'h2, after reset -> outputs 4'h1 (lane 0), then 4'h2 (lane 1) on consecutive edges.
REQ-034 Overflow: pause=1, push 5 words 4'h1..4'h5 on lane 1 -> full_1=1 after the 4th; 5th dropped, err_overflow=2'b10; release pause -> output 1,2,3,4 on lane 1 only.
REQ-035 Full with simultaneous pop: lane 0 full, pause=0, valid_0=1 -> push accepted, count stays 4, err_overflow[0] stays 0.
REQ-036 Wrap: stream 10 words on lane 0 with pause=0 -> output order identical to input, across pointer wrap.
REQ-037 Reset mid-operation: 3 words buffered in lane 1, assert reset between edges -> valid_out=0, full/almost_full=0 immediately; no buffered word appears after release.
